dbus_mem_responder: RTL and testbench
=====================================

// Module: dbus_mem_responder
// PURPOSE
//   Responder (slave) end of the core data bus: accepts one dbus request at a time
//   and completes it after a fixed latency against an internal 64-bit-wide SRAM.
//   Sits between core.dreq/dresp and the memory model in sim/FPGA tops.
//   Gives the core's memory stage a deterministic, multi-cycle data_ok stall source.
// PARAMETERS
//   MEM_WORDS  1024            number of 64-bit words in the SRAM
//   BASE_ADDR  64'h8000_0000   byte address of word 0
//   LATENCY    2               cycles from accept to data_ok; legal range 1..15
// PORTS
//   clk           in   1   clock
//   reset         in   1   synchronous, active-high reset
//   req_valid     in   1   request valid; held stable by initiator until data_ok
//   req_addr      in   64  byte address; bits [2:0] ignored
//   req_size      in   3   access size (msize_t); informational, lanes come from strobe
//   req_strobe    in   8   byte-lane write enables; 8'h00 = read
//   req_data      in   64  write data, lane-aligned
//   resp_addr_ok  out  1   request accepted this cycle
//   resp_data_ok  out  1   one-cycle completion pulse
//   resp_data     out  64  read data; valid only while resp_data_ok=1, else 0
//   busy          out  1   transaction in flight (state BUSY)
//   oor_seen      out  1   sticky: an out-of-range access has completed
//   txn_count     out  32  completed transactions, wraps 32'hFFFF_FFFF -> 0
// BEHAVIOUR
//   FSM: IDLE, BUSY. The address and data latch and the 4-bit cnt are registers.
//   IDLE: resp_addr_ok = req_valid, combinational.
//     On req_valid: latch addr/strobe/data, cnt <= LATENCY-1, go to BUSY.
//   BUSY, cnt != 0: cnt <= cnt-1. resp_addr_ok=0 and resp_data_ok=0.
//   BUSY, cnt == 0: resp_data_ok=1 and resp_data = mem[idx] (pre-write value).
//     At that clock edge: perform the write, txn_count++, go to IDLE.
//   Latency: accept at cycle T -> data_ok at cycle T+LATENCY.
//     No accept in the data_ok cycle, so throughput is 1 txn per LATENCY+1 cycles.
//   Index: idx = (addr - BASE_ADDR) >> 3.
//     In range iff addr >= BASE_ADDR and idx < MEM_WORDS. Compute in 64 bits; no wrap.
//   Write: when strobe != 0 and in range, byte i of mem[idx] <= data byte i iff strobe[i].
//   Out of range: read returns 64'h0, write is dropped, data_ok is still given.
//     oor_seen <= 1 at completion.
//   req_valid or the request fields changing after accept: ignored.
//     The latched values complete normally; this is an initiator protocol violation.
//   Reset (any cycle, incl. mid-transaction): state IDLE, cnt=0, oor_seen=0,
//     txn_count=0, resp_* = 0, busy=0. The in-flight write is abandoned; no data_ok.
//   Reset does not clear SRAM contents.
//   Outputs are 0 while reset is asserted. req_valid is ignored during reset.
// TESTING (LATENCY=2 unless stated)
//   1. Write 64'h1122_3344_5566_7788 @8000_0008, strb FF -> addr_ok @T, data_ok @T+2.
//      Read @8000_0008 -> data 1122_3344_5566_7788.
//   2. Read-back word = 64'h1122_3344_5566_7788, then write strb 8'h0F, data ...AABB_CCDD
//      -> read returns 1122_3344_AABB_CCDD; that write's data_ok shows the old word.
//   3. Hold req_valid high for 3 back-to-back reads -> data_ok at T+2, T+5, T+8;
//      txn_count=3.
//   4. Read @7FFF_FFF8 and write @8000_2000 (MEM_WORDS=1024) -> data 0, write dropped,
//      data_ok given, oor_seen=1.
//   5. Assert reset in the cycle after accepting a write -> no data_ok, word unchanged,
//      busy=0, txn_count=0.
//   6. LATENCY=1: accept @T -> data_ok @T+1. LATENCY=15: accept @T -> data_ok @T+15.

Source files
------------

// File: rtl/dbus_mem_responder_if.sv
// Data-bus request/response bundle between the core (master) and a memory responder (slave).
//   req_valid    request valid, held by the initiator until resp_data_ok
//   req_addr     byte address (low 3 bits ignored by the responder)
//   req_size     access size (informational)
//   req_strobe   byte-lane write enables, 8'h00 = read
//   req_data     lane-aligned write data
//   resp_addr_ok request accepted this cycle
//   resp_data_ok one-cycle completion pulse
//   resp_data    read data, valid only with resp_data_ok
interface dbus_mem_responder_if;
    logic        req_valid;
    logic [63:0] req_addr;
    logic [2:0]  req_size;
    logic [7:0]  req_strobe;
    logic [63:0] req_data;
    logic        resp_addr_ok;
    logic        resp_data_ok;
    logic [63:0] resp_data;

    modport master (
        output req_valid, req_addr, req_size, req_strobe, req_data,
        input  resp_addr_ok, resp_data_ok, resp_data
    );

    modport slave (
        input  req_valid, req_addr, req_size, req_strobe, req_data,
        output resp_addr_ok, resp_data_ok, resp_data
    );
endinterface

// File: rtl/dbus_mem_responder.sv
// Fixed-latency data-bus responder backed by an internal 64-bit-wide SRAM.
// Accepts one request at a time and completes it LATENCY cycles after accept.
//   clk        clock
//   reset      synchronous, active-high reset
//   bus        dbus slave port (request in, addr_ok/data_ok/data out)
//   busy       a transaction is in flight
//   oor_seen   sticky: an out-of-range access has completed
//   txn_count  completed transactions, wrapping
module dbus_mem_responder #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    dbus_mem_responder_if.slave  bus,
    output logic                 busy,
    output logic                 oor_seen,
    output logic [31:0]          txn_count
);

    localparam int unsigned IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned LANES  = DATA_W / 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                accept;
    logic                complete;
    logic [CNT_W-1:0]    cnt_q;
    logic [60:0]         word_q;
    logic [LANES-1:0]    strobe_q;
    logic [DATA_W-1:0]   data_q;
    logic                oor_q;
    logic [31:0]         count_q;
    logic [DATA_W-1:0]   mem [MEM_WORDS];

    logic [63:0]         word_addr;
    logic [63:0]         offset;
    logic                in_range;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   rd_word;

    // Size is informational and the byte offset is ignored.
    logic                unused_bits;
    assign unused_bits = ^{bus.req_size, bus.req_addr[2:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus accept/complete strobes.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        complete = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Latency counter and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            oor_q   <= 1'b0;
            count_q <= '0;
        end else begin
            if (accept) begin
                cnt_q <= CNT_W'(LATENCY - 1);
            end else if (state_q == S_BUSY && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (complete) begin
                count_q <= count_q + 32'd1;
                if (!in_range) begin
                    oor_q <= 1'b1;
                end
            end
        end
    end

    // Request latch; later changes on the bus are ignored until completion.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            word_q   <= bus.req_addr[63:3];
            strobe_q <= bus.req_strobe;
            data_q   <= bus.req_data;
        end
    end

    // Address decode in full 64-bit arithmetic so nothing wraps into range.
    assign word_addr = {word_q, 3'b000};
    assign offset    = word_addr - BASE_ADDR;
    assign in_range  = (word_addr >= BASE_ADDR) && ((offset >> 3) < 64'(MEM_WORDS));
    assign idx       = offset[IDX_W+2:3];
    assign rd_word   = in_range ? mem[idx] : '0;

    // Byte-lane write at completion; the SRAM is never reset.
    always_ff @(posedge clk) begin
        if (!reset && complete && in_range) begin
            for (int i = 0; i < LANES; i++) begin
                if (strobe_q[i]) begin
                    mem[idx][8*i +: 8] <= data_q[8*i +: 8];
                end
            end
        end
    end

    // Outputs forced low while reset is asserted.
    assign bus.resp_addr_ok = !reset && accept;
    assign bus.resp_data_ok = !reset && complete;
    assign bus.resp_data    = (!reset && complete) ? rd_word : '0;
    assign busy             = !reset && (state_q == S_BUSY);
    assign oor_seen         = !reset && oor_q;
    assign txn_count        = reset ? '0 : count_q;

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Directed bench for dbus_mem_responder at LATENCY 2, 1 and 15.
module tb_dbus_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;

    logic        req_valid;
    logic [63:0] req_addr;
    logic [2:0]  req_size;
    logic [7:0]  req_strobe;
    logic [63:0] req_data;
    int          sel;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dbus_mem_responder_if bus0 ();
    dbus_mem_responder_if bus1 ();
    dbus_mem_responder_if bus2 ();

    assign bus0.req_valid  = req_valid && (sel == 0);
    assign bus1.req_valid  = req_valid && (sel == 1);
    assign bus2.req_valid  = req_valid && (sel == 2);
    assign bus0.req_addr   = req_addr;
    assign bus1.req_addr   = req_addr;
    assign bus2.req_addr   = req_addr;
    assign bus0.req_size   = req_size;
    assign bus1.req_size   = req_size;
    assign bus2.req_size   = req_size;
    assign bus0.req_strobe = req_strobe;
    assign bus1.req_strobe = req_strobe;
    assign bus2.req_strobe = req_strobe;
    assign bus0.req_data   = req_data;
    assign bus1.req_data   = req_data;
    assign bus2.req_data   = req_data;

    logic        busy0, busy1, busy2;
    logic        oor0, oor1, oor2;
    logic [31:0] cnt0, cnt1, cnt2;

    dbus_mem_responder #(.LATENCY(2)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave),
        .busy(busy0), .oor_seen(oor0), .txn_count(cnt0)
    );
    dbus_mem_responder #(.LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave),
        .busy(busy1), .oor_seen(oor1), .txn_count(cnt1)
    );
    dbus_mem_responder #(.LATENCY(15)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave),
        .busy(busy2), .oor_seen(oor2), .txn_count(cnt2)
    );

    logic        m_addr_ok, m_data_ok, m_busy, m_oor;
    logic [63:0] m_data;
    logic [31:0] m_count;

    always_comb begin
        m_addr_ok = bus0.resp_addr_ok;
        m_data_ok = bus0.resp_data_ok;
        m_data    = bus0.resp_data;
        m_busy    = busy0;
        m_oor     = oor0;
        m_count   = cnt0;
        if (sel == 1) begin
            m_addr_ok = bus1.resp_addr_ok;
            m_data_ok = bus1.resp_data_ok;
            m_data    = bus1.resp_data;
            m_busy    = busy1;
            m_oor     = oor1;
            m_count   = cnt1;
        end else if (sel == 2) begin
            m_addr_ok = bus2.resp_addr_ok;
            m_data_ok = bus2.resp_data_ok;
            m_data    = bus2.resp_data;
            m_busy    = busy2;
            m_oor     = oor2;
            m_count   = cnt2;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after data_ok.
    task automatic txn(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                       output logic [63:0] rd, output int t_acc, output int t_ok);
        int n;
        req_valid  = 1'b1;
        req_addr   = a;
        req_strobe = s;
        req_data   = d;
        req_size   = 3'd3;
        #1;
        n = 0;
        while (m_addr_ok !== 1'b1 && n < 40) begin
            @(posedge clk); #2;
            n++;
        end
        check("addr_ok", 64'(m_addr_ok), 64'd1);
        t_acc = cyc;
        @(posedge clk); #2;
        n = 0;
        while (m_data_ok !== 1'b1 && n < 40) begin
            check("wait_addr_ok_low", 64'(m_addr_ok), 64'd0);
            check("wait_data_zero", m_data, 64'd0);
            check("wait_busy", 64'(m_busy), 64'd1);
            @(posedge clk); #2;
            n++;
        end
        check("data_ok", 64'(m_data_ok), 64'd1);
        t_ok = cyc;
        rd   = m_data;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        int ta, to, ta1, to1, to2, to3;

        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = '0;
        req_strobe = '0; req_data = '0; sel = 0;
        repeat (3) @(posedge clk);
        #1;

        // Reset: valid ignored, outputs held low
        req_valid = 1'b1;
        req_addr  = 64'h8000_0000;
        #1;
        check("rst_addr_ok", 64'(m_addr_ok), 64'd0);
        check("rst_busy", 64'(m_busy), 64'd0);
        check("rst_count", 64'(m_count), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        #1;
        check("post_rst_busy", 64'(m_busy), 64'd0);
        check("post_rst_oor", 64'(m_oor), 64'd0);
        check("post_rst_data_ok", 64'(m_data_ok), 64'd0);
        @(posedge clk); #1;

        // Test 1: full write then read
        txn(64'h8000_0008, 8'hFF, 64'h1122_3344_5566_7788, rd, ta, to);
        check("t1_latency", 64'(to - ta), 64'd2);
        txn(64'h8000_0008, 8'h00, 64'd0, rd, ta, to);
        check("t1_read", rd, 64'h1122_3344_5566_7788);
        check("t1_count", 64'(m_count), 64'd2);

        // Test 2: partial write returns old word, merges lanes
        txn(64'h8000_000C, 8'h0F, 64'h0000_0000_AABB_CCDD, rd, ta, to);
        check("t2_old_word", rd, 64'h1122_3344_5566_7788);
        txn(64'h8000_0008, 8'h00, 64'd0, rd, ta, to);
        check("t2_merged", rd, 64'h1122_3344_AABB_CCDD);
        txn(64'h8000_0000, 8'hFF, 64'hCAFE_F00D_0123_4567, rd, ta, to);
        txn(64'h8000_0010, 8'hFF, 64'h0F0E_0D0C_0B0A_0908, rd, ta, to);
        check("t2_count", 64'(m_count), 64'd6);

        // Test 3: back-to-back reads with valid held high
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("t3_count_cleared", 64'(m_count), 64'd0);
        @(posedge clk); #1;
        txn(64'h8000_0008, 8'h00, 64'd0, rd, ta1, to1);
        check("t3_rd1", rd, 64'h1122_3344_AABB_CCDD);
        txn(64'h8000_0000, 8'h00, 64'd0, rd, ta, to2);
        check("t3_rd2", rd, 64'hCAFE_F00D_0123_4567);
        txn(64'h8000_0010, 8'h00, 64'd0, rd, ta, to3);
        check("t3_rd3", rd, 64'h0F0E_0D0C_0B0A_0908);
        check("t3_lat1", 64'(to1 - ta1), 64'd2);
        check("t3_ok2", 64'(to2 - ta1), 64'd5);
        check("t3_ok3", 64'(to3 - ta1), 64'd8);
        check("t3_count", 64'(m_count), 64'd3);

        // Test 4: out-of-range and last in-range word
        check("t4_oor_before", 64'(m_oor), 64'd0);
        txn(64'h7FFF_FFF8, 8'h00, 64'd0, rd, ta, to);
        check("t4_oor_read", rd, 64'd0);
        check("t4_oor_set", 64'(m_oor), 64'd1);
        txn(64'h8000_2000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, rd, ta, to);
        check("t4_oor_wr_data", rd, 64'd0);
        txn(64'h8000_0000, 8'h00, 64'd0, rd, ta, to);
        check("t4_word0_kept", rd, 64'hCAFE_F00D_0123_4567);
        txn(64'h8000_1FF8, 8'hFF, 64'h0123_4567_89AB_CDEF, rd, ta, to);
        txn(64'h8000_1FF8, 8'h00, 64'd0, rd, ta, to);
        check("t4_last_word", rd, 64'h0123_4567_89AB_CDEF);
        check("t4_count", 64'(m_count), 64'd8);

        // Test 5: reset mid-transaction abandons the write
        req_valid = 1'b1; req_addr = 64'h8000_0010; req_strobe = 8'hFF;
        req_data  = 64'h5555_5555_5555_5555;
        #1;
        check("t5_accept", 64'(m_addr_ok), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("t5_rst_busy", 64'(m_busy), 64'd0);
        check("t5_rst_data_ok", 64'(m_data_ok), 64'd0);
        check("t5_rst_oor", 64'(m_oor), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t5_no_data_ok", 64'(m_data_ok), 64'd0);
            check("t5_idle", 64'(m_busy), 64'd0);
            @(posedge clk); #1;
        end
        check("t5_count", 64'(m_count), 64'd0);
        txn(64'h8000_0010, 8'h00, 64'd0, rd, ta, to);
        check("t5_word_kept", rd, 64'h0F0E_0D0C_0B0A_0908);

        // Test 6: latency extremes
        sel = 1;
        #1;
        @(posedge clk); #1;
        txn(64'h8000_0000, 8'hFF, 64'h0000_0000_0000_0001, rd, ta, to);
        check("t6_l1_wr_lat", 64'(to - ta), 64'd1);
        txn(64'h8000_0000, 8'h00, 64'd0, rd, ta, to);
        check("t6_l1_rd_lat", 64'(to - ta), 64'd1);
        check("t6_l1_data", rd, 64'd1);
        sel = 2;
        #1;
        @(posedge clk); #1;
        txn(64'h8000_0000, 8'hFF, 64'h0000_0000_0000_0002, rd, ta, to);
        check("t6_l15_wr_lat", 64'(to - ta), 64'd15);
        txn(64'h8000_0000, 8'h00, 64'd0, rd, ta, to);
        check("t6_l15_rd_lat", 64'(to - ta), 64'd15);
        check("t6_l15_data", rd, 64'd2);
        check("t6_l15_count", 64'(m_count), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
